// File: rtl/dat_rx_deserializer_if.sv
// dat_rx_deserializer_if: DAT receive bus between pads/read control (master) and the deserializer (slave)
interface dat_rx_deserializer_if #(parameter int MaxBlockBitSize = 10);
    logic [3:0] dat;
    logic start;
    logic [MaxBlockBitSize-1:0] block_size;
    logic bus_width_is_4;
    logic busy;
    logic data_valid;
    logic [31:0] data;
    logic done;
    logic crc_err;
    logic end_bit_err;
    modport master(output dat, start, block_size, bus_width_is_4,
                   input busy, data_valid, data, done, crc_err, end_bit_err);
    modport slave(input dat, start, block_size, bus_width_is_4,
                  output busy, data_valid, data, done, crc_err, end_bit_err);
endinterface

// File: rtl/dat_rx_deserializer.sv
// dat_rx_deserializer: SD DAT-line block receiver, 1/4-bit, little-endian word packing, per-line CRC16 and end-bit check
module dat_rx_deserializer #(parameter int MaxBlockBitSize = 10) (
    input logic sd_clk,
    input logic rst,
    dat_rx_deserializer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WAIT_START, DATA, CRC, END_BIT} state_t;
    localparam logic [MaxBlockBitSize-1:0] One = 1;
    state_t state, next;
    logic w4;
    logic [MaxBlockBitSize-1:0] size, byte_cnt;
    logic [2:0] bit_cnt;
    logic [3:0] crc_cnt;
    logic [7:0] sh;
    logic [15:0] crc [4];
    logic [31:0] acc, data;
    logic dv, done, crc_err, end_err;
    logic accept, sbit, byte_done, last;
    logic [3:0] act, crc_msb;
    logic [7:0] byte_val;
    logic [31:0] word;
    always_comb begin
        act = w4 ? 4'hf : 4'h1;
        accept = state == IDLE && bus.start && !done;
        sbit = w4 ? bus.dat == 4'h0 : !bus.dat[0];
        byte_done = state == DATA && bit_cnt == (w4 ? 3'd1 : 3'd7);
        last = byte_cnt == size - One;
        byte_val = w4 ? {sh[3:0], bus.dat} : {sh[6:0], bus.dat[0]};
        crc_msb = {crc[3][15], crc[2][15], crc[1][15], crc[0][15]};
        word = byte_cnt[1:0] == 2'd0 ? 32'h0 : acc;
        word[8*byte_cnt[1:0] +: 8] = byte_val;
    end
    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= next;
    end
    always_comb begin
        next = state;
        case (state)
            IDLE: next = accept ? WAIT_START : IDLE;
            WAIT_START: next = !sbit ? WAIT_START : size == '0 ? CRC : DATA;
            DATA: next = byte_done && last ? CRC : DATA;
            CRC: next = &crc_cnt ? END_BIT : CRC;
            END_BIT: next = IDLE;
            default: next = IDLE;
        endcase
    end
    always_comb begin
        bus.busy = state != IDLE;
        bus.data_valid = dv;
        bus.data = data;
        bus.done = done;
        bus.crc_err = crc_err;
        bus.end_bit_err = end_err;
    end
    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            w4 <= 1'b0;
            size <= '0;
            byte_cnt <= '0;
            bit_cnt <= '0;
            crc_cnt <= '0;
            sh <= '0;
            crc <= '{default: '0};
            acc <= '0;
            data <= '0;
            dv <= 1'b0;
            done <= 1'b0;
            crc_err <= 1'b0;
            end_err <= 1'b0;
        end else begin
            dv <= 1'b0;
            done <= 1'b0;
            if (accept) begin
                w4 <= bus.bus_width_is_4;
                size <= bus.block_size;
                byte_cnt <= '0;
                bit_cnt <= '0;
                crc_cnt <= '0;
                crc <= '{default: '0};
                crc_err <= 1'b0;
                end_err <= 1'b0;
            end
            if (state == DATA) begin
                sh <= byte_val;
                bit_cnt <= byte_done ? 3'd0 : bit_cnt + 3'd1;
                // inactive lines also run their CRC; they are masked at compare time
                for (int l = 0; l < 4; l++)
                    crc[l] <= {crc[l][14:0], 1'b0} ^ ({16{bus.dat[l] ^ crc[l][15]}} & 16'h1021);
                if (byte_done) begin
                    byte_cnt <= byte_cnt + One;
                    acc <= word;
                    if (byte_cnt[1:0] == 2'd3 || last) begin
                        data <= word;
                        dv <= 1'b1;
                    end
                end
            end
            if (state == CRC) begin
                crc_cnt <= crc_cnt + 4'd1;
                for (int l = 0; l < 4; l++) crc[l] <= {crc[l][14:0], 1'b0};
                if (|((bus.dat ^ crc_msb) & act)) crc_err <= 1'b1;
            end
            if (state == END_BIT) begin
                if (|(~bus.dat & act)) end_err <= 1'b1;
                done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dat_rx_deserializer.sv
// tb_dat_rx_deserializer: randomized block reception checked against a queue/polynomial-division reference model
module tb_dat_rx_deserializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    dat_rx_deserializer_if #(.MaxBlockBitSize(10)) bus();
    dat_rx_deserializer #(.MaxBlockBitSize(10)) dut(.sd_clk(clk), .rst(rst), .bus(bus));
    int tests = 0;
    int fails = 0;
    logic [7:0] blk [1024];
    typedef struct {int cyc; logic [31:0] w;} ev_t;
    ev_t q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // remainder of M(x)*x^16 divided by x^16+x^12+x^5+1, MSB first
    function automatic logic [15:0] crc16(input bit m[$]);
        bit r[$];
        logic [16:0] p = 17'h11021;
        logic [15:0] c;
        r = m;
        for (int i = 0; i < 16; i++) r.push_back(1'b0);
        for (int i = 0; i < m.size(); i++)
            if (r[i]) for (int j = 0; j < 17; j++) r[i+j] = r[i+j] ^ p[16-j];
        for (int j = 0; j < 16; j++) c[15-j] = r[m.size()+j];
        return c;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, bus.data, 32'h0);
        check({tag, "_flags"}, {27'h0, bus.busy, bus.data_valid, bus.done, bus.crc_err, bus.end_bit_err}, 32'h0);
    endtask

    task automatic run_block(input bit w4, input int n, input bit rnd, input int fl, input int fb,
                             input bit bad_end, input int pre, input bit repulse, input int abort_words);
        int bpb;
        int d;
        logic [3:0] vec [$];
        bit lb [4][$];
        bit tmp[$];
        logic [15:0] crc [4];
        logic [3:0] v;
        logic [31:0] w;
        bit exp_dv;
        bit spurious;
        int lastb;
        bpb = w4 ? 2 : 8;
        d = n * bpb;
        q.delete();
        if (rnd) for (int i = 0; i < n; i++) blk[i] = 8'($urandom);
        for (int i = 0; i < n; i++) begin
            if (w4) begin
                for (int h = 0; h < 2; h++) begin
                    v = h == 0 ? blk[i][7:4] : blk[i][3:0];
                    vec.push_back(v);
                    for (int l = 0; l < 4; l++) lb[l].push_back(v[l]);
                end
            end else begin
                for (int b = 7; b >= 0; b--) begin
                    v = 4'($urandom);
                    v[0] = blk[i][b];
                    vec.push_back(v);
                    lb[0].push_back(v[0]);
                end
            end
        end
        for (int l = 0; l < 4; l++) begin
            tmp = lb[l];
            crc[l] = crc16(tmp);
        end
        for (int k = 0; k < 16; k++) begin
            v = w4 ? {crc[3][15-k], crc[2][15-k], crc[1][15-k], crc[0][15-k]} : 4'($urandom);
            if (!w4) v[0] = crc[0][15-k];
            if (fl >= 0 && k == fb) v[fl] = ~v[fl];
            vec.push_back(v);
        end
        v = 4'($urandom);
        v[0] = !bad_end;
        vec.push_back(w4 ? (bad_end ? 4'b1011 : 4'hf) : v);
        for (int k = 0; 4 * k < n; k++) begin
            w = 32'h0;
            for (int j = 0; j < 4; j++) if (4 * k + j < n) w[8*j +: 8] = blk[4*k+j];
            lastb = 4 * k + 3 < n ? 4 * k + 3 : n - 1;
            q.push_back('{(lastb + 1) * bpb + 1, w});
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.bus_width_is_4 = w4;
        bus.block_size = 10'(n);
        for (int c = -pre; c <= d + 20; c++) begin
            @(negedge clk);
            exp_dv = q.size() > 0 && q[0].cyc == c;
            if (bus.data_valid || exp_dv) begin
                check("data_valid", {31'h0, bus.data_valid}, {31'h0, exp_dv});
                if (exp_dv) begin
                    check("data", bus.data, q[0].w);
                    void'(q.pop_front());
                end
            end
            if (bus.done || c == d + 18) begin
                check("done", {31'h0, bus.done}, {31'h0, c == d + 18});
                if (c == d + 18) begin
                    check("crc_err", {31'h0, bus.crc_err}, {31'h0, fl >= 0});
                    check("end_bit_err", {31'h0, bus.end_bit_err}, {31'h0, bad_end});
                    check("busy_done", {31'h0, bus.busy}, 32'h0);
                end
            end
            if (c == 0) check("busy_wait", {31'h0, bus.busy}, 32'h1);
            if (repulse && c == d + 19) check("busy_after", {31'h0, bus.busy}, 32'h0);
            if (abort_words > 0 && c == 4 * abort_words * bpb + 3) begin
                rst = 1'b1;
                bus.dat = 4'hf;
                bus.start = 1'b0;
                #1 check_reset_outputs("abort");
                repeat (3) @(negedge clk);
                check_reset_outputs("abort_hold");
                rst = 1'b0;
                spurious = 1'b0;
                repeat (40) begin
                    @(negedge clk);
                    spurious |= bus.done | bus.data_valid | bus.busy;
                end
                check("abort_quiet", {31'h0, spurious}, 32'h0);
                q.delete();
                return;
            end
            bus.start = repulse && (c == d / 2 || c == d + 18);
            v = 4'($urandom);
            v[0] = 1'b0;
            bus.dat = c < 0 ? (w4 ? 4'b1110 : 4'b0001) : c == 0 ? (w4 ? 4'h0 : v) : c <= d + 17 ? vec[c-1] : 4'hf;
        end
        bus.start = 1'b0;
        check("words_delivered", q.size(), 0);
    endtask

    initial begin
        bus.dat = 4'hf;
        bus.start = 1'b0;
        bus.block_size = '0;
        bus.bus_width_is_4 = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        blk[0] = 8'h12; blk[1] = 8'h34; blk[2] = 8'h56; blk[3] = 8'h78;
        run_block(1'b0, 4, 1'b0, -1, 0, 1'b0, 0, 1'b0, 0);
        run_block(1'b1, 512, 1'b1, -1, 0, 1'b0, 0, 1'b0, 0);
        run_block(1'b1, 8, 1'b1, 2, 5, 1'b0, 0, 1'b0, 0);
        run_block(1'b0, 5, 1'b1, -1, 0, 1'b1, 3, 1'b0, 0);
        run_block(1'b1, 64, 1'b1, -1, 0, 1'b0, 0, 1'b0, 10);
        run_block(1'b1, 16, 1'b1, -1, 0, 1'b0, 0, 1'b0, 0);
        run_block(1'b1, 20, 1'b1, -1, 0, 1'b0, 20, 1'b1, 0);
        run_block(1'b0, 0, 1'b1, -1, 0, 1'b0, 2, 1'b0, 0);
        run_block(1'b0, 3, 1'b1, 0, 9, 1'b0, 1, 1'b1, 0);
        for (int i = 0; i < 4; i++)
            run_block(1'($urandom), $urandom_range(1, 40), 1'b1, -1, 0, 1'($urandom), $urandom_range(0, 5), 1'b0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
